// File: rtl/gate_truth_seq_pkg.sv
// gate_truth_seq_pkg
//   Shared types and helpers for the gate truth-table sequencer.
//   - seq_state_e : sequencer FSM states
//   - cnt_width() : width of the shared settle/dwell down-counter
package gate_truth_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StDwell,
        StFin
    } seq_state_e;

    // The counter is loaded with (cycles - 1), so it must hold
    // max(settle, dwell). Never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned settle,
                                              input int unsigned dwell);
        int unsigned max_v;
        max_v = (settle > dwell) ? settle : dwell;
        if (max_v + 1 <= 2) begin
            return 1;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/gate_truth_seq_if.sv
// gate_truth_seq_if
//   Bundles the sequencer's control, gate drive and result signals.
//   Ports carried:
//     start        : single-cycle run request (honoured only when idle)
//     exp_tt       : expected truth table, latched on an accepted start
//     gate_in      : output of the gate being driven
//     vec_out      : input vector driven onto the gate
//     busy         : sequence in progress
//     sample_valid : one-cycle pulse per sampled vector
//     sample_vec   : vector sampled, valid with sample_valid
//     sample_val   : sampled gate value, valid with sample_valid
//     result_tt    : measured truth table
//     done         : one-cycle pulse at end of a sequence
//     pass         : result_tt matched exp_tt, held until the next accepted start
//   Modports: slave = the sequencer, master = whoever drives start and the gate.
interface gate_truth_seq_if #(
    parameter int unsigned N_IN = 2
);
    localparam int unsigned NVEC = 1 << N_IN;

    logic              start;
    logic [NVEC-1:0]   exp_tt;
    logic              gate_in;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              sample_valid;
    logic [N_IN-1:0]   sample_vec;
    logic              sample_val;
    logic [NVEC-1:0]   result_tt;
    logic              done;
    logic              pass;

    modport slave (
        input  start,
        input  exp_tt,
        input  gate_in,
        output vec_out,
        output busy,
        output sample_valid,
        output sample_vec,
        output sample_val,
        output result_tt,
        output done,
        output pass
    );

    modport master (
        output start,
        output exp_tt,
        output gate_in,
        input  vec_out,
        input  busy,
        input  sample_valid,
        input  sample_vec,
        input  sample_val,
        input  result_tt,
        input  done,
        input  pass
    );

endinterface

// File: rtl/gate_truth_seq_timer.sv
// seq_timer
//   Loadable down-counter with a zero flag. One instance times both the
//   settle and dwell phases; the owner reloads it on every phase entry.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset (count -> 0)
//     load     : load load_val this cycle (takes priority over dec)
//     load_val : value to load (phase length - 1)
//     dec      : decrement by one; saturates at zero
//     zero     : count is zero (phase ends this cycle)
module seq_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gate_truth_seq.sv
// gate_truth_seq
//   Truth-table sequencer for a small combinational gate. On an accepted
//   start it drives every input vector, descending from NVEC-1 to 0, holds
//   each for SETTLE_CYCLES before sampling the gate output, then for
//   DWELL_CYCLES after. Each vector period is SETTLE_CYCLES+DWELL_CYCLES+1
//   cycles. After vector 0 it spends one FIN cycle pulsing done and
//   publishing pass = (measured table == latched expected table).
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset; aborts any run without a done
//     bus : gate_truth_seq_if.slave (control, gate drive, results)
module gate_truth_seq
    import gate_truth_seq_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DWELL_CYCLES  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_seq_if.slave       bus
);

    localparam int unsigned NVEC = 1 << N_IN;
    localparam int unsigned CntW = cnt_width(SETTLE_CYCLES, DWELL_CYCLES);

    localparam logic [N_IN-1:0] VecMax     = N_IN'(NVEC - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
    // Dwell load is unused when DWELL_CYCLES is 0; keep it well defined.
    localparam logic [CntW-1:0] DwellLoad  =
        (DWELL_CYCLES == 0) ? '0 : CntW'(DWELL_CYCLES - 1);

    seq_state_e      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [NVEC-1:0] result_q, result_d;
    logic [NVEC-1:0] exp_q, exp_d;
    logic            pass_q, pass_d;
    logic            sval_q, sval_d;

    logic            timer_load;
    logic [CntW-1:0] timer_val;
    logic            timer_dec;
    logic            timer_zero;

    // Set in the cycle the current vector's period ends.
    logic            period_end;

    seq_timer #(
        .Width (CntW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        result_d   = result_q;
        exp_d      = exp_q;
        pass_d     = pass_q;
        sval_d     = sval_q;
        timer_load = 1'b0;
        timer_val  = SettleLoad;
        timer_dec  = 1'b0;
        period_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StSettle;
                    vec_d      = VecMax;
                    result_d   = '0;
                    pass_d     = 1'b0;
                    exp_d      = bus.exp_tt;
                    timer_load = 1'b1;
                    timer_val  = SettleLoad;
                end
            end

            StSettle: begin
                if (timer_zero) begin
                    // Last settle cycle: capture the gate at this edge so
                    // the sample is visible in the SAMPLE cycle.
                    state_d         = StSample;
                    sval_d          = bus.gate_in;
                    result_d[vec_q] = bus.gate_in;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            StSample: begin
                if (DWELL_CYCLES != 0) begin
                    state_d    = StDwell;
                    timer_load = 1'b1;
                    timer_val  = DwellLoad;
                end else begin
                    period_end = 1'b1;
                end
            end

            StDwell: begin
                if (timer_zero) begin
                    period_end = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Vector 0 terminates the run; the index never wraps back to NVEC-1.
        if (period_end) begin
            if (vec_q == '0) begin
                state_d = StFin;
                vec_d   = '0;
                pass_d  = (result_q == exp_q);
            end else begin
                state_d    = StSettle;
                vec_d      = vec_q - N_IN'(1);
                timer_load = 1'b1;
                timer_val  = SettleLoad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            vec_q    <= '0;
            result_q <= '0;
            exp_q    <= '0;
            pass_q   <= 1'b0;
            sval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            pass_q   <= pass_d;
            sval_q   <= sval_d;
        end
    end

    assign bus.vec_out      = vec_q;
    assign bus.busy         = (state_q == StSettle) || (state_q == StSample) ||
                              (state_q == StDwell);
    assign bus.sample_valid = (state_q == StSample);
    assign bus.sample_vec   = (state_q == StSample) ? vec_q : '0;
    assign bus.sample_val   = sval_q;
    assign bus.result_tt    = result_q;
    assign bus.done         = (state_q == StFin);
    assign bus.pass         = pass_q;

endmodule

// File: tb/tb_gate_truth_seq.sv
// tb_gate_truth_seq
//   Scoreboard bench. DUT A: defaults with an OR gate in the loop.
//   DUT B: N_IN=3, SETTLE_CYCLES=1, DWELL_CYCLES=0, gate tied low.
//   Stimulus pushes expected sample/done events; per-DUT monitors pop them
//   whenever sample_valid or done appears.
module tb_gate_truth_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_truth_seq_if #(.N_IN(2)) bus_a ();
    gate_truth_seq_if #(.N_IN(3)) bus_b ();

    // Two-input OR gate (orMod) in the loop of DUT A.
    assign bus_a.gate_in = bus_a.vec_out[0] | bus_a.vec_out[1];
    assign bus_b.gate_in = 1'b0;

    gate_truth_seq #(
        .N_IN          (2),
        .SETTLE_CYCLES (2),
        .DWELL_CYCLES  (15)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    gate_truth_seq #(
        .N_IN          (3),
        .SETTLE_CYCLES (1),
        .DWELL_CYCLES  (0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        int   cyc;
        int   vec;
        logic val;
    } samp_t;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        pass;
    } done_t;

    samp_t qa_s[$];
    samp_t qb_s[$];
    done_t qa_d[$];
    done_t qb_d[$];
    samp_t sa_e, sb_e;
    done_t da_e, db_e;

    // Defaults, OR gate: offsets from the start cycle, vectors, sampled values.
    localparam int A_OFF[4] = '{3, 21, 39, 57};
    localparam int A_VEC[4] = '{3, 2, 1, 0};
    localparam int A_VAL[4] = '{1, 1, 1, 0};
    localparam int A_DONE   = 73;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.sample_valid) begin
                if (qa_s.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected_sample: got vec %0d at cycle %0d, expected none",
                             bus_a.sample_vec, cyc);
                end else begin
                    sa_e = qa_s.pop_front();
                    check("a_sample_cycle", cyc, sa_e.cyc);
                    check("a_sample_vec", 32'(bus_a.sample_vec), sa_e.vec);
                    check("a_sample_val", 32'(bus_a.sample_val), 32'(sa_e.val));
                end
            end
            if (bus_a.done) begin
                if (qa_d.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    da_e = qa_d.pop_front();
                    check("a_done_cycle", cyc, da_e.cyc);
                    check("a_done_result", 32'(bus_a.result_tt), da_e.res);
                    check("a_done_pass", 32'(bus_a.pass), 32'(da_e.pass));
                    check("a_done_busy", 32'(bus_a.busy), 0);
                    check("a_done_vec", 32'(bus_a.vec_out), 0);
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_b.sample_valid) begin
                if (qb_s.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected_sample: got vec %0d at cycle %0d, expected none",
                             bus_b.sample_vec, cyc);
                end else begin
                    sb_e = qb_s.pop_front();
                    check("b_sample_cycle", cyc, sb_e.cyc);
                    check("b_sample_vec", 32'(bus_b.sample_vec), sb_e.vec);
                    check("b_sample_val", 32'(bus_b.sample_val), 32'(sb_e.val));
                end
            end
            if (bus_b.done) begin
                if (qb_d.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    db_e = qb_d.pop_front();
                    check("b_done_cycle", cyc, db_e.cyc);
                    check("b_done_result", 32'(bus_b.result_tt), db_e.res);
                    check("b_done_pass", 32'(bus_b.pass), 32'(db_e.pass));
                    check("b_done_busy", 32'(bus_b.busy), 0);
                end
            end
        end
    end

    // Start a default run on DUT A; t is the cycle whose closing edge samples start.
    task automatic run_a(input logic [3:0] exp, input logic exp_pass, output int t);
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            qa_s.push_back('{t + A_OFF[i], A_VEC[i], (A_VAL[i] != 0)});
        end
        qa_d.push_back('{t + A_DONE, 32'b1110, exp_pass});
        bus_a.exp_tt = exp;
        bus_a.start  = 1'b1;
        tick();
        bus_a.start  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((qa_s.size() + qa_d.size() + qb_s.size() + qb_d.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        if (qa_s.size() + qa_d.size() + qb_s.size() + qb_d.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d events outstanding, expected 0",
                     qa_s.size() + qa_d.size() + qb_s.size() + qb_d.size());
            qa_s.delete();
            qa_d.delete();
            qb_s.delete();
            qb_d.delete();
        end
    endtask

    initial begin
        int t;
        int t2;
        bus_a.start  = 1'b1;
        bus_a.exp_tt = 4'b1110;
        bus_b.start  = 1'b1;
        bus_b.exp_tt = 8'h00;
        rst          = 1'b1;

        // Reset held 3 cycles with start asserted.
        repeat (3) tick();
        check("rst_a_busy", 32'(bus_a.busy), 0);
        check("rst_a_done", 32'(bus_a.done), 0);
        check("rst_a_pass", 32'(bus_a.pass), 0);
        check("rst_a_vec", 32'(bus_a.vec_out), 0);
        check("rst_a_result", 32'(bus_a.result_tt), 0);
        check("rst_a_svalid", 32'(bus_a.sample_valid), 0);
        check("rst_b_busy", 32'(bus_b.busy), 0);
        check("rst_b_vec", 32'(bus_b.vec_out), 0);
        rst         = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        tick();
        tick();
        check("post_rst_a_busy", 32'(bus_a.busy), 0);
        check("post_rst_b_busy", 32'(bus_b.busy), 0);

        // Defaults, matching table.
        run_a(4'b1110, 1'b1, t);
        check("s1_start_busy", 32'(bus_a.busy), 1);
        check("s1_start_vec", 32'(bus_a.vec_out), 3);
        check("s1_start_result", 32'(bus_a.result_tt), 0);
        wait_drain(100);
        check("s1_idle_busy", 32'(bus_a.busy), 0);
        check("s1_idle_vec", 32'(bus_a.vec_out), 0);
        check("s1_pass_held", 32'(bus_a.pass), 1);

        // Mismatch: AND table expected. Start clears pass and result.
        run_a(4'b1000, 1'b0, t);
        check("s2_start_pass_clr", 32'(bus_a.pass), 0);
        check("s2_start_result_clr", 32'(bus_a.result_tt), 0);
        check("s2_start_vec", 32'(bus_a.vec_out), 3);
        wait_drain(100);
        repeat (5) tick();
        check("s2_pass_held", 32'(bus_a.pass), 0);
        check("s2_result_held", 32'(bus_a.result_tt), 32'b1110);

        // Extra starts mid-run and in the done cycle are ignored.
        run_a(4'b1110, 1'b1, t);
        wait_until(t + 10);
        bus_a.exp_tt = 4'b1000;
        bus_a.start  = 1'b1;
        tick();
        bus_a.start  = 1'b0;
        wait_until(t + A_DONE);
        check("s3_done_now", 32'(bus_a.done), 1);
        bus_a.start  = 1'b1;
        tick();
        bus_a.start  = 1'b0;
        check("s3_no_restart_busy", 32'(bus_a.busy), 0);
        check("s3_no_restart_vec", 32'(bus_a.vec_out), 0);
        check("s3_exp_not_relatched", 32'(bus_a.pass), 1);
        tick();
        check("s3_still_idle", 32'(bus_a.busy), 0);
        wait_drain(10);

        // Reset mid-run aborts without done.
        run_a(4'b1110, 1'b1, t);
        wait_until(t + 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qa_s.delete();
        qa_d.delete();
        check("s4_abort_busy", 32'(bus_a.busy), 0);
        check("s4_abort_vec", 32'(bus_a.vec_out), 0);
        check("s4_abort_result", 32'(bus_a.result_tt), 0);
        check("s4_abort_done", 32'(bus_a.done), 0);
        wait_until(t + 80);
        check("s4_stays_idle", 32'(bus_a.busy), 0);
        run_a(4'b1110, 1'b1, t2);
        wait_drain(100);
        check("s4_rerun_pass", 32'(bus_a.pass), 1);

        // Edge parameters on DUT B: 8 vectors, period 2, gate low.
        t = cyc;
        for (int i = 0; i < 8; i++) begin
            qb_s.push_back('{t + 2 + 2 * i, 7 - i, 1'b0});
        end
        qb_d.push_back('{t + 17, 32'h0, 1'b1});
        bus_b.exp_tt = 8'h00;
        bus_b.start  = 1'b1;
        tick();
        bus_b.start  = 1'b0;
        check("s5_start_busy", 32'(bus_b.busy), 1);
        check("s5_start_vec", 32'(bus_b.vec_out), 7);
        wait_drain(40);
        check("s5_idle_busy", 32'(bus_b.busy), 0);
        check("s5_pass_held", 32'(bus_b.pass), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
